// File: rtl/ppi_pkg.sv
// Shared types, constants and helpers for the PPI bus sequencer.
package ppi_pkg;

    typedef enum logic [1:0] {
        PORT_WR = 2'b00,
        PORT_RD = 2'b01,
        CTRL_WR = 2'b10,
        BSR     = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        FAIL   = 3'd4
    } seq_state_t;

    localparam logic [1:0] PPI_A    = 2'b00;
    localparam logic [1:0] PPI_B    = 2'b01;
    localparam logic [1:0] PPI_C    = 2'b10;
    localparam logic [1:0] PPI_CTRL = 2'b11;

    localparam logic [7:0] CTRL_DEFAULT = 8'h9B;

    localparam int unsigned CW_MODE_FLAG = 7;
    localparam int unsigned CW_A_IN      = 4;
    localparam int unsigned CW_CU_IN     = 3;
    localparam int unsigned CW_B_IN      = 1;
    localparam int unsigned CW_CL_IN     = 0;

    // One latched requester command
    typedef struct packed {
        cmd_t       cmd;
        logic [1:0] addr;
        logic [7:0] wdata;
    } ppi_cmd_t;

    // Every command except a port read drives PD
    function automatic logic is_write(input cmd_t c);
        return c != PORT_RD;
    endfunction

    // Port commands address their port; control/BSR commands hit the control register
    function automatic logic [1:0] bus_addr(input ppi_cmd_t p);
        return (p.cmd == PORT_WR || p.cmd == PORT_RD) ? p.addr : PPI_CTRL;
    endfunction

    // Byte placed on PD for a write-type command
    function automatic logic [7:0] pd_word(input ppi_cmd_t p);
        logic [7:0] w;
        w = p.wdata;
        case (p.cmd)
            CTRL_WR: w[CW_MODE_FLAG] = 1'b1;
            BSR:     w = {4'b0000, p.wdata[3:0]};
            default: w = p.wdata;
        endcase
        return w;
    endfunction

    // True when the control word configures the addressed port as input
    function automatic logic port_is_input(input logic [7:0] cw, input logic [1:0] addr);
        case (addr)
            PPI_A:   return cw[CW_A_IN];
            PPI_B:   return cw[CW_B_IN];
            PPI_C:   return cw[CW_CL_IN] | cw[CW_CU_IN];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ppi_rr_arbiter.sv
// Two-way round-robin arbiter; ptr names the requester that wins the next tie.
module ppi_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       gnt_en,
    output logic       gnt_valid_c,
    output logic       gnt_id_c
);

    logic ptr;

    // Grant decision: single request wins outright, a tie goes to ptr
    always_comb begin
        gnt_valid_c = gnt_en && (req != 2'b00);
        gnt_id_c    = (req == 2'b11) ? ptr : req[1];
    end

    // Pointer moves to the other requester after every grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (gnt_valid_c) begin
            ptr <= ~gnt_id_c;
        end
    end

endmodule

// File: rtl/ppi_bus_sequencer.sv
// Host-side PPI bus sequencer: arbitrates two requesters and runs timed
// setup / strobe / hold bus cycles on the 8255-style pins.
// Optional macro PPI_SEQ_MODE_SHADOW_EN adds a control-word shadow and a
// port-direction check on port writes.
module ppi_bus_sequencer
    import ppi_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic [1:0] CMD0,
    input  logic [1:0] ADDR0,
    input  logic [7:0] WDATA0,
    output logic       DONE0,
    input  logic       REQ1,
    input  logic [1:0] CMD1,
    input  logic [1:0] ADDR1,
    input  logic [7:0] WDATA1,
    output logic       DONE1,
    output logic       ERR,
    output logic [7:0] RDATA,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic [1:0] A,
    output logic [7:0] PD_OUT,
    output logic       PD_OE,
    input  logic [7:0] PD_IN,
    output logic       BUSY
`ifdef PPI_SEQ_MODE_SHADOW_EN
    ,
    output logic [7:0] CFG_SHADOW
`endif
);

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    ppi_cmd_t         cur, cur_nxt;
    logic             id, id_nxt;

    logic             gnt_valid_c;
    logic             gnt_id_c;
    ppi_cmd_t         sel_c;
    logic             reject_c;

    logic             cs_nxt, rd_nxt, wr_nxt, oe_nxt;
    logic [1:0]       a_nxt;
    logic [7:0]       pd_nxt;
    logic             done_nxt, err_nxt;

    ppi_rr_arbiter u_arb (
        .clk         (CLK),
        .rst         (RST),
        .req         ({REQ1, REQ0}),
        .gnt_en      (state == IDLE),
        .gnt_valid_c (gnt_valid_c),
        .gnt_id_c    (gnt_id_c)
    );

    // Command of the requester currently winning arbitration and its legality
    always_comb begin
        sel_c = gnt_id_c ? ppi_cmd_t'({cmd_t'(CMD1), ADDR1, WDATA1})
                         : ppi_cmd_t'({cmd_t'(CMD0), ADDR0, WDATA0});
        reject_c = (sel_c.cmd == PORT_WR || sel_c.cmd == PORT_RD) && (sel_c.addr == PPI_CTRL);
`ifdef PPI_SEQ_MODE_SHADOW_EN
        if (sel_c.cmd == PORT_WR && port_is_input(CFG_SHADOW, sel_c.addr)) begin
            reject_c = 1'b1;
        end
`endif
    end

    // Next state, phase counter and next values of the registered pins
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cur_nxt   = cur;
        id_nxt    = id;
        cs_nxt    = 1'b1;
        rd_nxt    = 1'b1;
        wr_nxt    = 1'b1;
        oe_nxt    = 1'b0;
        a_nxt     = A;
        pd_nxt    = PD_OUT;

        case (state)
            IDLE: begin
                if (gnt_valid_c) begin
                    cur_nxt = sel_c;
                    id_nxt  = gnt_id_c;
                    if (reject_c) begin
                        state_nxt = FAIL;
                    end else begin
                        state_nxt = SETUP;
                        cnt_nxt   = CNT_W'(SETUP_CYC - 1);
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = CNT_W'(STROBE_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            FAIL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == SETUP || state_nxt == STROBE || state_nxt == HOLD) begin
            cs_nxt = 1'b0;
            a_nxt  = bus_addr(cur_nxt);
            if (is_write(cur_nxt.cmd)) begin
                oe_nxt = 1'b1;
                pd_nxt = pd_word(cur_nxt);
            end
        end
        if (state_nxt == STROBE) begin
            rd_nxt = (cur_nxt.cmd != PORT_RD);
            wr_nxt = (cur_nxt.cmd == PORT_RD);
        end

        done_nxt = (state_nxt == FAIL) || (state_nxt == HOLD && cnt_nxt == '0);
        err_nxt  = (state_nxt == FAIL);
    end

    // State and pin registers; reset releases the bus immediately
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            cur    <= '0;
            id     <= 1'b0;
            CS     <= 1'b1;
            RD     <= 1'b1;
            WR     <= 1'b1;
            A      <= 2'b00;
            PD_OUT <= 8'h00;
            PD_OE  <= 1'b0;
            RDATA  <= 8'h00;
            DONE0  <= 1'b0;
            DONE1  <= 1'b0;
            ERR    <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            cur    <= cur_nxt;
            id     <= id_nxt;
            CS     <= cs_nxt;
            RD     <= rd_nxt;
            WR     <= wr_nxt;
            A      <= a_nxt;
            PD_OUT <= pd_nxt;
            PD_OE  <= oe_nxt;
            DONE0  <= done_nxt && !id_nxt;
            DONE1  <= done_nxt && id_nxt;
            ERR    <= err_nxt;
            BUSY   <= (state_nxt != IDLE);
            if (state == STROBE && cnt == '0 && cur.cmd == PORT_RD) begin
                RDATA <= PD_IN;
            end
        end
    end

`ifdef PPI_SEQ_MODE_SHADOW_EN
    // Shadow follows each completed control-word write
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CFG_SHADOW <= CTRL_DEFAULT;
        end else if (done_nxt && !err_nxt && cur_nxt.cmd == CTRL_WR) begin
            CFG_SHADOW <= pd_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Self-checking bench for ppi_bus_sequencer: directed vector table, corner
// sequences, and a randomized run against a transaction-level model.
module tb_ppi_bus_sequencer;

    localparam int S = 1;
    localparam int T = 2;
    localparam int H = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] cmd0 = 2'd0, cmd1 = 2'd0, addr0 = 2'd0, addr1 = 2'd0;
    logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00, pd_in = 8'h00;
    logic       done0, done1, err, cs, rd, wr, pd_oe, busy;
    logic [1:0] a;
    logic [7:0] rdata, pd_out;
`ifdef PPI_SEQ_MODE_SHADOW_EN
    logic [7:0] cfg_shadow;
`endif

    int total = 0;
    int bad   = 0;

    ppi_bus_sequencer #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .CNT_W(4)) dut (
        .CLK(clk), .RST(rst),
        .REQ0(req0), .CMD0(cmd0), .ADDR0(addr0), .WDATA0(wdata0), .DONE0(done0),
        .REQ1(req1), .CMD1(cmd1), .ADDR1(addr1), .WDATA1(wdata1), .DONE1(done1),
        .ERR(err), .RDATA(rdata), .CS(cs), .RD(rd), .WR(wr), .A(a),
        .PD_OUT(pd_out), .PD_OE(pd_oe), .PD_IN(pd_in), .BUSY(busy)
`ifdef PPI_SEQ_MODE_SHADOW_EN
        , .CFG_SHADOW(cfg_shadow)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack(input logic c, input logic r, input logic w,
                                         input logic [1:0] ad, input logic [7:0] pd,
                                         input logic oe, input logic [7:0] rdt,
                                         input logic d0, input logic d1, input logic e,
                                         input logic b);
        return {6'b0, c, r, w, ad, pd, oe, rdt, d0, d1, e, b};
    endfunction

    function automatic logic [31:0] obs();
        return pack(cs, rd, wr, a, pd_out, pd_oe, rdata, done0, done1, err, busy);
    endfunction

    typedef struct {
        logic       id;
        logic [1:0] cmd;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] pdin;
        int         done_cyc;
        logic       err;
        logic       cs_seen;
        logic [1:0] a;
        logic [7:0] pd;
        logic       oe;
        int         wr_n;
        int         rd_n;
        logic [7:0] rdata;
    } vec_t;

    // Single transaction from an idle bus: raise REQ now, watch until DONE
    task automatic run_vec(input string name, input vec_t v);
        logic       got = 1'b0, seen = 1'b0, derr = 1'b0;
        logic [1:0] ca = 2'd0;
        logic [7:0] cpd = 8'h00, drd = 8'h00;
        logic       coe = 1'b0;
        int         wrn = 0, rdn = 0, dcyc = 0;
        pd_in = v.pdin;
        if (v.id) begin
            cmd1 = v.cmd; addr1 = v.addr; wdata1 = v.wdata; req1 = 1'b1;
        end else begin
            cmd0 = v.cmd; addr0 = v.addr; wdata0 = v.wdata; req0 = 1'b1;
        end
        for (int c = 1; c <= 20 && !got; c++) begin
            tick();
            if (!cs && !seen) begin
                seen = 1'b1; ca = a; cpd = pd_out; coe = pd_oe;
            end
            if (!wr) wrn++;
            if (!rd) rdn++;
            if (v.id ? done1 : done0) begin
                got = 1'b1; dcyc = c; derr = err; drd = rdata;
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        if (!got) check({name, "_timeout"}, 64'd0, 64'd1);
        check({name, "_done"}, {8'(dcyc), derr, drd}, {8'(v.done_cyc), v.err, v.rdata});
        check({name, "_bus"}, {seen, ca, cpd, coe}, {v.cs_seen, v.a, v.pd, v.oe});
        check({name, "_strb"}, {8'(wrn), 8'(rdn)}, {8'(v.wr_n), 8'(v.rd_n)});
        tick();
    endtask

    // Randomized-run model state
    logic       m_act = 1'b0, m_fail = 1'b0, m_id = 1'b0, m_ptr = 1'b0;
    int         m_k = 0, m_tot = 0;
    logic [1:0] m_cmd = 2'd0, m_addr = 2'd0;
    logic [7:0] m_wd = 8'h00, e_a_pd = 8'h00, e_rdata = 8'h00, m_shadow = 8'h9B;
    logic [1:0] e_a = 2'd0;
    logic [1:0] granted = 2'b00;

    function automatic logic dir_in(input logic [7:0] cw, input logic [1:0] ad);
        return (ad == 2'd0) ? cw[4] : (ad == 2'd1) ? cw[1] : (ad == 2'd2) ? (cw[0] | cw[3]) : 1'b0;
    endfunction

    function automatic logic [7:0] word_of(input logic [1:0] c, input logic [7:0] w);
        return (c == 2'd2) ? (8'h80 | (w & 8'h7F)) : (c == 2'd3) ? (w & 8'h0F) : w;
    endfunction

    // One requester's behaviour per cycle: drop at DONE, maybe raise, scramble after grant
    task automatic drive_req(input int n, input logic dn);
        logic r;
        r = (n == 0) ? req0 : req1;
        if (dn) begin
            r = 1'b0;
            granted[n] = 1'b0;
        end else if (!r && $urandom_range(3) == 0) begin
            r = 1'b1;
        end else if (!(r && granted[n])) begin
            return;
        end
        if (n == 0) begin
            req0 = r; cmd0 = 2'($urandom); addr0 = 2'($urandom); wdata0 = 8'($urandom);
        end else begin
            req1 = r; cmd1 = 2'($urandom); addr1 = 2'($urandom); wdata1 = 8'($urandom);
        end
    endtask

    vec_t vt[11];
    logic [3:0] seq;
    int         ndone;
    logic       prev_done;

    initial begin
        vt[0]  = '{1'b0, 2'd2, 2'd0, 8'h00, 8'h00, 4, 1'b0, 1'b1, 2'd3, 8'h80, 1'b1, 2, 0, 8'h00};
        vt[1]  = '{1'b1, 2'd1, 2'd1, 8'h00, 8'h99, 4, 1'b0, 1'b1, 2'd1, 8'h80, 1'b0, 0, 2, 8'h99};
        vt[2]  = '{1'b0, 2'd3, 2'd0, 8'h0F, 8'h00, 4, 1'b0, 1'b1, 2'd3, 8'h0F, 1'b1, 2, 0, 8'h99};
        vt[3]  = '{1'b0, 2'd0, 2'd3, 8'hAA, 8'h00, 1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 0, 0, 8'h99};
        vt[4]  = '{1'b1, 2'd0, 2'd2, 8'hA5, 8'h00, 4, 1'b0, 1'b1, 2'd2, 8'hA5, 1'b1, 2, 0, 8'h99};
        vt[5]  = '{1'b1, 2'd1, 2'd3, 8'h00, 8'h42, 1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 0, 0, 8'h99};
        vt[6]  = '{1'b0, 2'd3, 2'd1, 8'hF3, 8'h00, 4, 1'b0, 1'b1, 2'd3, 8'h03, 1'b1, 2, 0, 8'h99};
        vt[7]  = '{1'b1, 2'd2, 2'd0, 8'h64, 8'h00, 4, 1'b0, 1'b1, 2'd3, 8'hE4, 1'b1, 2, 0, 8'h99};
        vt[8]  = '{1'b0, 2'd0, 2'd0, 8'h3C, 8'h00, 4, 1'b0, 1'b1, 2'd0, 8'h3C, 1'b1, 2, 0, 8'h99};
        vt[9]  = '{1'b1, 2'd1, 2'd2, 8'h00, 8'h5A, 4, 1'b0, 1'b1, 2'd2, 8'h3C, 1'b0, 0, 2, 8'h5A};
        vt[10] = '{1'b0, 2'd1, 2'd0, 8'h00, 8'hC3, 4, 1'b0, 1'b1, 2'd0, 8'h3C, 1'b0, 0, 2, 8'hC3};

        // Reset values
        tick();
        tick();
        check("reset_state", 64'(obs()), 64'(pack(1, 1, 1, 2'd0, 8'h00, 0, 8'h00, 0, 0, 0, 0)));
`ifdef PPI_SEQ_MODE_SHADOW_EN
        check("reset_shadow", 64'(cfg_shadow), 64'h9B);
`endif
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vt[i]);

        // Reset asserted while WR is low
        cmd0 = 2'd2; addr0 = 2'd0; wdata0 = 8'h00; req0 = 1'b1;
        begin
            logic hit = 1'b0;
            for (int c = 0; c < 10 && !hit; c++) begin
                tick();
                if (!wr) hit = 1'b1;
            end
            check("midrst_reach_strobe", 64'(hit), 64'd1);
        end
        rst = 1'b1;
        #1;
        check("midrst_async", 64'({wr, cs, pd_oe, busy}), 64'b1100);
        req0 = 1'b0;
        tick();
        tick();
        check("midrst_no_done", 64'({done0, done1, err}), 64'd0);
        rst = 1'b0;
        tick();
        check("midrst_after", 64'(obs()), 64'(pack(1, 1, 1, 2'd0, 8'h00, 0, 8'h00, 0, 0, 0, 0)));

        // Both requesters hold REQ: grants alternate starting with requester 0
        cmd0 = 2'd0; addr0 = 2'd0; wdata0 = 8'h11;
        cmd1 = 2'd0; addr1 = 2'd1; wdata1 = 8'h22;
        req0 = 1'b1; req1 = 1'b1;
        seq = 4'd0; ndone = 0; prev_done = 1'b0;
        for (int c = 0; c < 60 && ndone < 4; c++) begin
            tick();
            if (prev_done) check($sformatf("alt_gap%0d", ndone), 64'({cs, done0, done1}), 64'b100);
            prev_done = done0 | done1;
            if (done0 && done1) check("alt_both_done", 64'd1, 64'd0);
            if (done0 | done1) begin
                seq = {seq[2:0], done1};
                ndone++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("alt_order", {32'(ndone), 28'd0, seq}, {32'd4, 28'd0, 4'b0101});
        tick();
        tick();

`ifdef PPI_SEQ_MODE_SHADOW_EN
        // Control word 0x90 configures port A input, port B output
        run_vec("shd_cw", '{1'b0, 2'd2, 2'd0, 8'h90, 8'h00, 4, 1'b0, 1'b1, 2'd3, 8'h90, 1'b1, 2, 0, 8'h00});
        check("shd_value", 64'(cfg_shadow), 64'h90);
        run_vec("shd_porta", '{1'b0, 2'd0, 2'd0, 8'h11, 8'h00, 1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 0, 0, 8'h00});
        run_vec("shd_portb", '{1'b0, 2'd0, 2'd1, 8'h22, 8'h00, 4, 1'b0, 1'b1, 2'd1, 8'h22, 1'b1, 2, 0, 8'h00});
`endif

        // Randomized traffic against the transaction-level model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic ecs, erd, ewr, eoe, ed0, ed1, eerr, ebusy, fin;
            tick();
            if (m_act) begin
                m_k++;
                if (m_k > m_tot) m_act = 1'b0;
            end
            ecs = 1'b1; erd = 1'b1; ewr = 1'b1; eoe = 1'b0; eerr = 1'b0; ebusy = 1'b0; fin = 1'b0;
            if (m_act) begin
                ebusy = 1'b1;
                fin = (m_k == m_tot);
                if (m_fail) begin
                    eerr = 1'b1;
                end else begin
                    ecs = 1'b0;
                    eoe = (m_cmd != 2'd1);
                    if (m_k > S && m_k <= S + T) begin
                        if (m_cmd == 2'd1) erd = 1'b0;
                        else ewr = 1'b0;
                    end
                    if (fin && m_cmd == 2'd2) m_shadow = e_a_pd;
                end
            end
            ed0 = fin && !m_id;
            ed1 = fin && m_id;
            check("rand_cycle", 64'(obs()),
                  64'(pack(ecs, erd, ewr, e_a, e_a_pd, eoe, e_rdata, ed0, ed1, eerr, ebusy)));
`ifdef PPI_SEQ_MODE_SHADOW_EN
            check("rand_shadow", 64'(cfg_shadow), 64'(m_shadow));
`endif
            drive_req(0, ed0);
            drive_req(1, ed1);
            pd_in = 8'($urandom);
            if (m_act && !m_fail && m_cmd == 2'd1 && m_k == S + T) e_rdata = pd_in;
            if (!m_act && (req0 || req1)) begin
                m_id  = (req0 && req1) ? m_ptr : req1;
                m_ptr = ~m_id;
                m_cmd = m_id ? cmd1 : cmd0;
                m_addr = m_id ? addr1 : addr0;
                m_wd  = m_id ? wdata1 : wdata0;
                m_fail = (m_cmd <= 2'd1 && m_addr == 2'd3);
`ifdef PPI_SEQ_MODE_SHADOW_EN
                if (m_cmd == 2'd0 && dir_in(m_shadow, m_addr)) m_fail = 1'b1;
`endif
                m_tot = m_fail ? 1 : S + T + H;
                m_k = 0;
                m_act = 1'b1;
                granted[m_id] = 1'b1;
                if (!m_fail) begin
                    e_a = (m_cmd <= 2'd1) ? m_addr : 2'd3;
                    if (m_cmd != 2'd1) e_a_pd = word_of(m_cmd, m_wd);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
